// File: rtl/sensor_scan_ctrl.sv
// sensor_scan_ctrl
// Periodic scan controller for a four-input sensor error check. The sensor pins
// are captured once every SCAN_PERIOD clocks while scanning is enabled, and the
// error rule is evaluated on that captured sample. An error has to be seen on
// DEBOUNCE consecutive samples before the sticky alarm is raised. The alarm
// stays up until software acknowledges it, and every raise bumps a saturating
// fault counter.
//
// Ports:
//   clk             system clock, rising edge
//   n_rst           asynchronous active-low reset
//   enable          scanning enabled when high
//   sensors         raw sensor levels
//   clear_alarm     single-cycle acknowledge, clears a raised alarm
//   sample_valid    one-cycle pulse, sensors_latched was just updated
//   sensors_latched last captured sensor sample
//   error_now       error rule applied to sensors_latched
//   alarm           sticky debounced alarm
//   alarm_src       sample that raised the current alarm
//   fault_count     number of alarm raises, saturating at all-ones
module sensor_scan_ctrl #(
    parameter int SCAN_PERIOD = 8,
    parameter int DEBOUNCE    = 3,
    parameter int FCNT_W      = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              enable,
    input  logic [3:0]        sensors,
    input  logic              clear_alarm,
    output logic              sample_valid,
    output logic [3:0]        sensors_latched,
    output logic              error_now,
    output logic              alarm,
    output logic [3:0]        alarm_src,
    output logic [FCNT_W-1:0] fault_count
);

    localparam int SCAN_W = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;
    localparam int DEB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE - 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX  = {FCNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        MONITOR,
        PENDING,
        ALARM
    } state_t;

    state_t            state;
    logic [SCAN_W-1:0] scan_cnt;
    logic [DEB_W-1:0]  deb_cnt;

    // The error rule: sensor 0 on its own is an error, sensor 1 is only an
    // error when backed up by sensor 2 or sensor 3. It looks at the registered
    // sample, so it is glitch-free and changes only when a new sample lands.
    always_comb begin
        error_now = sensors_latched[0]
                  | (sensors_latched[1] & sensors_latched[2])
                  | (sensors_latched[1] & sensors_latched[3]);
    end

    // Scan timer. While enabled it free-runs 0..SCAN_PERIOD-1 and captures the
    // pins on the last count, raising sample_valid for exactly one cycle. When
    // disabled the timer is parked at 0 so a re-enable always waits a full
    // period before the first sample; the last captured sample is kept.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scan_cnt        <= '0;
            sample_valid    <= 1'b0;
            sensors_latched <= '0;
        end else if (enable) begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt        <= '0;
                sample_valid    <= 1'b1;
                sensors_latched <= sensors;
            end else begin
                scan_cnt     <= scan_cnt + SCAN_W'(1);
                sample_valid <= 1'b0;
            end
        end else begin
            scan_cnt     <= '0;
            sample_valid <= 1'b0;
        end
    end

    // Debounce and alarm state machine. Samples are only judged in the cycle
    // sample_valid is high. A clean sample restarts the debounce run; the
    // DEBOUNCE-th consecutive erroring sample raises the alarm, records the
    // offending sample and bumps the fault counter (which sticks at all-ones).
    // Once alarmed, samples are ignored and the alarm survives enable going
    // low; only clear_alarm brings it down, and that clear takes priority over
    // any sample arriving in the same cycle, so the debounce run restarts
    // from zero.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            deb_cnt     <= '0;
            alarm       <= 1'b0;
            alarm_src   <= '0;
            fault_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    deb_cnt <= '0;
                    if (enable) begin
                        state <= MONITOR;
                    end
                end
                MONITOR, PENDING: begin
                    if (!enable) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (sample_valid) begin
                        if (!error_now) begin
                            state   <= MONITOR;
                            deb_cnt <= '0;
                        end else if (deb_cnt == DEB_LAST) begin
                            state     <= ALARM;
                            deb_cnt   <= '0;
                            alarm     <= 1'b1;
                            alarm_src <= sensors_latched;
                            if (fault_count != FCNT_MAX) begin
                                fault_count <= fault_count + FCNT_W'(1);
                            end
                        end else begin
                            state   <= PENDING;
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end
                    end
                end
                ALARM: begin
                    if (clear_alarm) begin
                        alarm     <= 1'b0;
                        alarm_src <= '0;
                        deb_cnt   <= '0;
                        state     <= enable ? MONITOR : IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    deb_cnt <= '0;
                end
            endcase
        end
    end

endmodule
